// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the Memory-stage pipeline and a debug read port.
// It latches one command per access and stalls the pipeline across the memory read latency.
module dmem_arbiter #(
    parameter int RD_LAT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PReq,
    input  logic        PWr,
    input  logic [31:0] PAddr,
    input  logic [31:0] PWData,
    input  logic [1:0]  PType,
    output logic [31:0] PRData,
    output logic        PStall,
    input  logic        DReq,
    input  logic [31:0] DAddr,
    output logic        DAck,
    output logic [31:0] DRData,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [1:0]  MemType,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] MemRData
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic OWN_P = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

    logic [1:0]  state_q,      state_d;
    logic        owner_q,      owner_d;
    logic        last_owner_q, last_owner_d;
    logic [1:0]  cnt_q,        cnt_d;
    logic        cmd_wr_q,     cmd_wr_d;
    logic [31:0] mem_addr_q,   mem_addr_d;
    logic [31:0] mem_wdata_q,  mem_wdata_d;
    logic [1:0]  mem_type_q,   mem_type_d;
    logic        mem_read_q,   mem_read_d;
    logic        mem_write_q,  mem_write_d;
    logic [31:0] prdata_q,     prdata_d;
    logic [31:0] drdata_q,     drdata_d;
    logic        dack_q,       dack_d;
    logic        grant_s;

    // Next-state logic: arbitration in IDLE, latency sequencing in ISSUE, one-cycle DONE
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        cmd_wr_d     = cmd_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_type_d   = mem_type_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        prdata_d     = prdata_q;
        drdata_d     = drdata_q;
        dack_d       = 1'b0;
        grant_s      = OWN_P;

        case (state_q)
            S_IDLE: begin
                // On a conflict the side that did not go last wins, giving strict alternation
                if (PReq && DReq) begin
                    grant_s = (last_owner_q == OWN_D) ? OWN_P : OWN_D;
                end else if (DReq) begin
                    grant_s = OWN_D;
                end else begin
                    grant_s = OWN_P;
                end

                if (PReq || DReq) begin
                    owner_d      = grant_s;
                    last_owner_d = grant_s;
                    cnt_d        = 2'd0;
                    state_d      = S_ISSUE;
                    if (grant_s == OWN_P) begin
                        cmd_wr_d    = PWr;
                        mem_addr_d  = PAddr;
                        mem_wdata_d = PWData;
                        mem_type_d  = PType;
                        mem_read_d  = ~PWr;
                        mem_write_d = PWr;
                    end else begin
                        cmd_wr_d    = 1'b0;
                        mem_addr_d  = DAddr;
                        mem_wdata_d = 32'h0000_0000;
                        mem_type_d  = 2'b00;
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ISSUE: begin
                if (cmd_wr_q) begin
                    state_d = S_DONE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_P) begin
                        prdata_d = MemRData;
                    end else begin
                        drdata_d = MemRData;
                        dack_d   = 1'b1;
                    end
                end else begin
                    cnt_d      = cnt_q + 2'd1;
                    mem_read_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight without capture
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_P;
            last_owner_q <= OWN_D;
            cnt_q        <= 2'd0;
            cmd_wr_q     <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
            mem_type_q   <= 2'b00;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            prdata_q     <= 32'h0000_0000;
            drdata_q     <= 32'h0000_0000;
            dack_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            cmd_wr_q     <= cmd_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_type_q   <= mem_type_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            prdata_q     <= prdata_d;
            drdata_q     <= drdata_d;
            dack_q       <= dack_d;
        end
    end

    // The pipeline is released only in the DONE cycle of its own access
    assign PStall   = PReq & ~((state_q == S_DONE) & (owner_q == OWN_P));

    assign PRData   = prdata_q;
    assign DRData   = drdata_q;
    assign DAck     = dack_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
    assign MemType  = mem_type_q;
    assign MemRead  = mem_read_q;
    assign MemWrite = mem_write_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table against an RD_LAT=2 instance,
// plus a hand-written debug read sequence on an RD_LAT=1 instance.
module tb_dmem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset, PReq, PWr, DReq;
    logic [31:0] PAddr, PWData, DAddr;
    logic [1:0]  PType;

    logic [31:0] PRData, DRData, MemAddr, MemWData, MemRData;
    logic [1:0]  MemType;
    logic        PStall, DAck, MemRead, MemWrite;

    logic [31:0] PRData1, DRData1, MemAddr1, MemWData1, MemRData1;
    logic [1:0]  MemType1;
    logic        PStall1, DAck1, MemRead1, MemWrite1;

    int checks = 0;
    int errors = 0;
    int row    = 0;

    always #5 Clk = ~Clk;

    // Memory contents seen by the bench
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h20)      return 32'h1234_5678;
        else if (a == 32'h40) return 32'hCAFE_F00D;
        else                  return {a[15:0], 16'hBEEF};
    endfunction

    assign MemRData  = mem_word(MemAddr);
    assign MemRData1 = mem_word(MemAddr1);

    dmem_arbiter #(.RD_LAT(2)) u2 (
        .Clk(Clk), .Reset(Reset), .PReq(PReq), .PWr(PWr), .PAddr(PAddr), .PWData(PWData),
        .PType(PType), .PRData(PRData), .PStall(PStall), .DReq(DReq), .DAddr(DAddr),
        .DAck(DAck), .DRData(DRData), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemType(MemType), .MemRead(MemRead), .MemWrite(MemWrite), .MemRData(MemRData)
    );

    dmem_arbiter #(.RD_LAT(1)) u1 (
        .Clk(Clk), .Reset(Reset), .PReq(PReq), .PWr(PWr), .PAddr(PAddr), .PWData(PWData),
        .PType(PType), .PRData(PRData1), .PStall(PStall1), .DReq(DReq), .DAddr(DAddr),
        .DAck(DAck1), .DRData(DRData1), .MemAddr(MemAddr1), .MemWData(MemWData1),
        .MemType(MemType1), .MemRead(MemRead1), .MemWrite(MemWrite1), .MemRData(MemRData1)
    );

    typedef struct {
        logic        rst, preq, pwr;
        logic [31:0] paddr, pwdata;
        logic [1:0]  ptype;
        logic        dreq;
        logic [31:0] daddr;
        logic        e_stall, e_rd, e_wr;
        logic [31:0] e_addr;
        logic [1:0]  e_type;
        logic        e_dack;
        logic [31:0] e_prdata, e_drdata;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, preq, pwr, input logic [31:0] paddr, pwdata,
                       input logic [1:0] ptype, input logic dreq, input logic [31:0] daddr,
                       input logic st, rd, wr, input logic [31:0] ea, input logic [1:0] et,
                       input logic dk, input logic [31:0] epr, edr);
        vec_t v;
        v.rst = rst; v.preq = preq; v.pwr = pwr; v.paddr = paddr; v.pwdata = pwdata;
        v.ptype = ptype; v.dreq = dreq; v.daddr = daddr; v.e_stall = st; v.e_rd = rd;
        v.e_wr = wr; v.e_addr = ea; v.e_type = et; v.e_dack = dk; v.e_prdata = epr;
        v.e_drdata = edr;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Reset = v.rst; PReq = v.preq; PWr = v.pwr; PAddr = v.paddr;
        PWData = v.pwdata; PType = v.ptype; DReq = v.dreq; DAddr = v.daddr;
    endtask

    initial begin
        Reset = 1'b1; PReq = 1'b0; PWr = 1'b0; DReq = 1'b0;
        PAddr = 32'h0; PWData = 32'h0; DAddr = 32'h0; PType = 2'b00;

        //   rst   preq  pwr   paddr   pwdata        ptype dreq  daddr  | stall rd    wr    addr    type  dack  prdata         drdata
        add(1'b1, 1'b1, 1'b0, 32'h00, 32'h0,        2'b00, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0,         32'h0);
        add(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0,         32'h0);
        add(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h10, 2'b10, 1'b0, 32'h0,         32'h0);
        add(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0,         32'h0);
        add(1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        2'b00, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0,         32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h20, 32'h0,        2'b00, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0,         32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h20, 32'h0,        2'b00, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h20, 2'b00, 1'b0, 32'h0,         32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h99, 32'h0,        2'b00, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h20, 2'b00, 1'b0, 32'h0,         32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h99, 32'h0,        2'b00, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h12345678,  32'h0);
        add(1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        2'b00, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h12345678,  32'h0);
        add(1'b1, 1'b0, 1'b0, 32'h00, 32'h0,        2'b00, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h12345678,  32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h30, 32'h0,        2'b01, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0,         32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h30, 32'h0,        2'b01, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 32'h30, 2'b01, 1'b0, 32'h0,         32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h30, 32'h0,        2'b01, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 32'h30, 2'b01, 1'b0, 32'h0,         32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h30, 32'h0,        2'b01, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0030BEEF,  32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h50, 32'h0,        2'b01, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0030BEEF,  32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h50, 32'h0,        2'b01, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 32'h40, 2'b00, 1'b0, 32'h0030BEEF,  32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h50, 32'h0,        2'b01, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 32'h40, 2'b00, 1'b0, 32'h0030BEEF,  32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h50, 32'h0,        2'b01, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h00, 2'b00, 1'b1, 32'h0030BEEF,  32'hCAFEF00D);
        add(1'b0, 1'b1, 1'b0, 32'h50, 32'h0,        2'b01, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0030BEEF,  32'hCAFEF00D);
        add(1'b0, 1'b1, 1'b0, 32'h50, 32'h0,        2'b01, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h50, 2'b01, 1'b0, 32'h0030BEEF,  32'hCAFEF00D);
        add(1'b0, 1'b1, 1'b0, 32'h50, 32'h0,        2'b01, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h50, 2'b01, 1'b0, 32'h0030BEEF,  32'hCAFEF00D);
        add(1'b0, 1'b1, 1'b0, 32'h50, 32'h0,        2'b01, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0050BEEF,  32'hCAFEF00D);
        add(1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        2'b00, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0050BEEF,  32'hCAFEF00D);
        add(1'b0, 1'b1, 1'b0, 32'h60, 32'h0,        2'b00, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0050BEEF,  32'hCAFEF00D);
        add(1'b1, 1'b1, 1'b0, 32'h60, 32'h0,        2'b00, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h60, 2'b00, 1'b0, 32'h0050BEEF,  32'hCAFEF00D);
        add(1'b0, 1'b1, 1'b0, 32'h60, 32'h0,        2'b00, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0,         32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h60, 32'h0,        2'b00, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h60, 2'b00, 1'b0, 32'h0,         32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h60, 32'h0,        2'b00, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h60, 2'b00, 1'b0, 32'h0,         32'h0);
        add(1'b0, 1'b1, 1'b0, 32'h60, 32'h0,        2'b00, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0060BEEF,  32'h0);
        add(1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        2'b00, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0060BEEF,  32'h0);

        @(posedge Clk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge Clk);
            row = i;
            drive(tbl[i]);
            #1;
            chk("PStall",   {31'h0, PStall},   {31'h0, tbl[i].e_stall});
            chk("MemRead",  {31'h0, MemRead},  {31'h0, tbl[i].e_rd});
            chk("MemWrite", {31'h0, MemWrite}, {31'h0, tbl[i].e_wr});
            chk("DAck",     {31'h0, DAck},     {31'h0, tbl[i].e_dack});
            chk("PRData",   PRData,            tbl[i].e_prdata);
            chk("DRData",   DRData,            tbl[i].e_drdata);
            if (tbl[i].e_rd || tbl[i].e_wr) begin
                chk("MemAddr", MemAddr,           tbl[i].e_addr);
                chk("MemType", {30'h0, MemType},  {30'h0, tbl[i].e_type});
            end
            if (tbl[i].e_wr) begin
                chk("MemWData", MemWData, tbl[i].pwdata);
            end
        end

        // Debug-only word read through the RD_LAT=1 instance
        row = 100;
        @(negedge Clk);
        Reset = 1'b1; PReq = 1'b0; DReq = 1'b0; PType = 2'b11;
        @(negedge Clk);
        Reset = 1'b0; DReq = 1'b1; DAddr = 32'h40;
        #1;
        chk("dbg_stall_t0", {31'h0, PStall1}, 32'h0);
        chk("dbg_dack_t0",  {31'h0, DAck1},   32'h0);
        chk("dbg_drdata_rst", DRData1,        32'h0);
        row = 101;
        @(negedge Clk);
        #1;
        chk("dbg_rd_t1",    {31'h0, MemRead1}, 32'h1);
        chk("dbg_addr_t1",  MemAddr1,          32'h40);
        chk("dbg_type_t1",  {30'h0, MemType1}, 32'h0);
        chk("dbg_dack_t1",  {31'h0, DAck1},    32'h0);
        chk("dbg_stall_t1", {31'h0, PStall1},  32'h0);
        row = 102;
        @(negedge Clk);
        #1;
        chk("dbg_dack_t2",   {31'h0, DAck1},    32'h1);
        chk("dbg_drdata_t2", DRData1,           32'hCAFEF00D);
        chk("dbg_rd_t2",     {31'h0, MemRead1}, 32'h0);
        chk("dbg_stall_t2",  {31'h0, PStall1},  32'h0);
        row = 103;
        @(negedge Clk);
        DReq = 1'b0;
        #1;
        chk("dbg_dack_t3",   {31'h0, DAck1},    32'h0);
        chk("dbg_drdata_t3", DRData1,           32'hCAFEF00D);
        chk("dbg_prdata_t3", PRData1,           32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and access sequencer for the single-port data memory. It shares the memory between the pipeline's Memory stage and a debug/display read port, and drives the command. It also stretches Memory-stage accesses over the memory's multi-cycle read latency by stalling the pipeline. It sits between the Memory-stage pipeline register outputs and the data memory instance.

## Interface
- RD_LAT, 2, memory read latency in cycles; legal range 1..4.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- PReq  in  1  pipeline access request (MemReadM | MemWriteM); held stable while PStall=1.
- PWr  in  1  1 = write, 0 = read; qualified by PReq.
- PAddr  in  32  pipeline byte address (ALUResultM).
- PWData  in  32  pipeline write data (ReadData2M).
- PType  in  2  access size code (MemTypeM); forwarded unchanged.
- PRData  out  32  registered pipeline read data.
- PStall  out  1  hold Fetch..Memory stages; combinational.
- DReq  in  1  debug read request; held until DAck.
- DAddr  in  32  debug word address.
- DAck  out  1  one-cycle completion pulse for a debug read.
- DRData  out  32  registered debug read data.
- MemAddr  out  32  registered memory address.
- MemWData  out  32  registered memory write data.
- MemType  out  2  registered size code; debug reads use 2'b00 (word).
- MemRead  out  1  registered read strobe.
- MemWrite  out  1  registered write strobe.
- MemRData  in  32  memory read data; valid in the last MemRead cycle.

## Operation
- FSM states: IDLE, ISSUE, DONE.
- Registers: owner (P/D), lastOwner, a 2-bit issue counter, and a latched command (addr, wdata, type, wr).
- IDLE, no request: stay in IDLE; MemRead=MemWrite=0.
- IDLE, only PReq: owner=P.
- IDLE, only DReq: owner=D.
- IDLE, both: owner = the side that is not lastOwner. lastOwner resets to D, so the pipeline wins the first conflict.
- On accepting a request: latch the command, load MemAddr/MemWData/MemType, set MemRead=!wr or MemWrite=wr, clear the counter, go to ISSUE, set lastOwner=owner.
- ISSUE, write: lasts 1 cycle. MemWrite=1 for that cycle, then DONE.
- ISSUE, read: MemRead held high for RD_LAT cycles. In the cycle where counter==RD_LAT-1:
  - capture MemRData into PRData (owner P) or DRData (owner D);
  - drop MemRead;
  - go to DONE.
- DONE: MemRead=MemWrite=0.
  - Owner D: DAck=1 for this cycle only.
  - Owner P: the pipeline advances at the end of this cycle.
  - Always next state IDLE; no DONE->ISSUE shortcut.
- PStall = PReq & !(state==DONE & owner==P). A pending pipeline request is therefore stalled while debug owns the memory.
- PAddr/PWData/DAddr changes after acceptance are ignored, because the command is latched.
- PType is passed through for pipeline accesses. Debug accesses are word reads only.

## Timing
- Reset values (after a clock edge with Reset=1):
  - state=IDLE, owner=P, lastOwner=D, counter=0;
  - MemRead=0, MemWrite=0, MemAddr=0, MemWData=0, MemType=0;
  - PRData=0, DRData=0, DAck=0.
- PStall during reset equals PReq.
- Reset mid-access aborts it with no data capture and no DAck. Strobes are 0 from the next cycle.
- Pipeline write accepted in cycle t:
  - PStall=1 in t and t+1; MemWrite=1 in t+1;
  - PStall=0 in t+2 (DONE).
  - 3 cycles per write.
- Pipeline read accepted in cycle t:
  - MemRead=1 in t+1..t+RD_LAT;
  - PStall=1 in t..t+RD_LAT;
  - PRData valid and PStall=0 in t+RD_LAT+1.
  - RD_LAT+2 cycles per read.
- Debug read accepted in t: DAck=1 and DRData valid in t+RD_LAT+1. DRData holds until the next debug capture.
- Minimum gap between accepted requests: one IDLE cycle after DONE.
- Starvation bound under continuous requests from both sides: strict alternation, so each side waits at most one access of the other.

## Test plan
- Write, RD_LAT=2: PReq=1, PWr=1, PAddr=0x10, PWData=0xDEADBEEF at t -> MemWrite=1 with MemAddr=0x10 at t+1; PStall=1 at t and t+1, 0 at t+2; DAck never 1.
- Read, RD_LAT=2: PReq=1, PWr=0, PAddr=0x20, memory returns 0x12345678 at t+2 -> MemRead=1 at t+1..t+2; PRData=0x12345678 and PStall=0 at t+3.
- Simultaneous PReq (read) and DReq right after reset -> pipeline is served first, PStall=0 at t+3. Debug is accepted at t+4 and DAck=1 at t+7. A second simultaneous pair goes to debug first.
- Debug-only read of DAddr=0x40 with RD_LAT=1 -> MemType=00, DAck=1 for exactly one cycle at t+2, DRData=memory word; PStall stays 0 throughout.
- Reset asserted in the first ISSUE cycle of a read -> next cycle MemRead=0 and state IDLE; PRData stays 0; no DAck. A reissued read completes normally.
- Pending PReq while debug is in ISSUE -> PStall stays 1 until the pipeline's own DONE; the pipeline command is not issued before the debug DONE.
